// File: rtl/serializer_pkg.sv
// rtl/serializer_pkg.sv - shared constants and state encoding for the output serializer
package serializer_pkg;

    localparam int NUM_ENCRYPTERS       = 4;
    localparam int ENCRYPTER_WIDTH      = 32;
    localparam int ENCRYPTER_QSPI_COUNT = ENCRYPTER_WIDTH / 4;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    localparam int NUM_ENCRYPTERS_REG       = clog2_min1(NUM_ENCRYPTERS);
    localparam int ENCRYPTER_QSPI_COUNT_REG = clog2_min1(ENCRYPTER_QSPI_COUNT);

    typedef enum logic [1:0] {
        SER_WAIT = 2'd0,
        SER_SEND = 2'd1
    } ser_state_e;

endpackage

// File: rtl/serializer_nibble_shift_reg.sv
// rtl/serializer_nibble_shift_reg.sv - parallel-load register shifting out MSB-first nibbles
module nibble_shift_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic [3:0]   top_nibble
);

    logic [W-1:0] buf_q;
    logic [W-1:0] buf_d;

    always_comb begin
        buf_d = buf_q;
        if (load) begin
            buf_d = din;
        end else if (shift) begin
            buf_d = buf_q << 4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

    assign top_nibble = buf_q[W-1 -: 4];

endmodule

// File: rtl/serializer.sv
// rtl/serializer.sv - round-robin collector of encrypted blocks, streamed out as QSPI nibbles
module serializer #(
    parameter int NUM_ENCRYPTERS           = serializer_pkg::NUM_ENCRYPTERS,
    parameter int ENCRYPTER_WIDTH          = serializer_pkg::ENCRYPTER_WIDTH,
    parameter int NUM_ENCRYPTERS_REG       = serializer_pkg::clog2_min1(NUM_ENCRYPTERS),
    parameter int ENCRYPTER_QSPI_COUNT_REG = serializer_pkg::clog2_min1(ENCRYPTER_WIDTH / 4)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                prog,
    input  logic [ENCRYPTER_WIDTH-1:0]          encrypters_result [NUM_ENCRYPTERS],
    input  logic [NUM_ENCRYPTERS-1:0]           encrypters_result_valid,
    output logic [NUM_ENCRYPTERS-1:0]           encrypters_result_ack,
    output logic [3:0]                          qspi_out_data,
    output logic                                qspi_out_valid,
    input  logic                                qspi_out_ready,
    output logic [1:0]                          state_out,
    output logic [NUM_ENCRYPTERS_REG-1:0]       encrypter_index_out,
    output logic [ENCRYPTER_QSPI_COUNT_REG-1:0] nibble_index_out
);
    import serializer_pkg::*;

    localparam int NIBBLES = ENCRYPTER_WIDTH / 4;
    localparam logic [NUM_ENCRYPTERS_REG-1:0]       LAST_IDX = NUM_ENCRYPTERS_REG'(NUM_ENCRYPTERS - 1);
    localparam logic [ENCRYPTER_QSPI_COUNT_REG-1:0] LAST_NIB = ENCRYPTER_QSPI_COUNT_REG'(NIBBLES - 1);

    ser_state_e                          state_q, state_d;
    logic [NUM_ENCRYPTERS_REG-1:0]       idx_q, idx_d, next_idx, sel_idx;
    logic [ENCRYPTER_QSPI_COUNT_REG-1:0] nib_q, nib_d;
    logic [NUM_ENCRYPTERS-1:0]           ack_q, ack_d;
    logic                                load, shift, clear;
    logic [ENCRYPTER_WIDTH-1:0]          load_data;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        nib_d    = nib_q;
        ack_d    = '0;
        load     = 1'b0;
        shift    = 1'b0;
        clear    = 1'b0;
        sel_idx  = idx_q;
        next_idx = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

        // prog drops any in-flight block and zeroes the buffer so the output idles at 0
        if (prog) begin
            state_d = SER_WAIT;
            idx_d   = '0;
            nib_d   = '0;
            load    = 1'b1;
            clear   = 1'b1;
        end else begin
            case (state_q)
                SER_WAIT: begin
                    if (encrypters_result_valid[idx_q] && !ack_q[idx_q]) begin
                        load         = 1'b1;
                        ack_d[idx_q] = 1'b1;
                        nib_d        = '0;
                        state_d      = SER_SEND;
                    end
                end
                SER_SEND: begin
                    if (qspi_out_ready) begin
                        if (nib_q == LAST_NIB) begin
                            idx_d = next_idx;
                            nib_d = '0;
                            // back-to-back: a stale ack on the next lane must not re-capture it
                            if (encrypters_result_valid[next_idx] && !ack_q[next_idx]) begin
                                load            = 1'b1;
                                sel_idx         = next_idx;
                                ack_d[next_idx] = 1'b1;
                            end else begin
                                shift   = 1'b1;
                                state_d = SER_WAIT;
                            end
                        end else begin
                            shift = 1'b1;
                            nib_d = nib_q + 1'b1;
                        end
                    end
                end
                default: state_d = SER_WAIT;
            endcase
        end

        load_data = clear ? '0 : encrypters_result[sel_idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SER_WAIT;
            idx_q   <= '0;
            nib_q   <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            nib_q   <= nib_d;
            ack_q   <= ack_d;
        end
    end

    nibble_shift_reg #(
        .W(ENCRYPTER_WIDTH)
    ) u_shift (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .shift      (shift),
        .din        (load_data),
        .top_nibble (qspi_out_data)
    );

    assign qspi_out_valid        = (state_q == SER_SEND);
    assign encrypters_result_ack = ack_q;
    assign state_out             = state_q;
    assign encrypter_index_out   = idx_q;
    assign nibble_index_out      = nib_q;

endmodule

// File: tb/tb_serializer.sv
// tb/tb_serializer.sv - directed self-checking bench for the serializer
module tb_serializer;

    localparam int N = 4;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         prog;
    logic [W-1:0] encrypters_result [N];
    logic [N-1:0] encrypters_result_valid;
    logic [N-1:0] encrypters_result_ack;
    logic [3:0]   qspi_out_data;
    logic         qspi_out_valid;
    logic         qspi_out_ready;
    logic [1:0]   state_out;
    logic [1:0]   encrypter_index_out;
    logic [2:0]   nibble_index_out;

    int n_checks = 0;
    int n_errors = 0;
    int idle_cnt = 0;

    logic [3:0] s_data;
    logic       s_valid;
    logic       s_ready;

    logic [3:0] got_nib [$];
    int         got_ack [$];
    logic [3:0] exp_nib [$];
    int         exp_ack [$];

    serializer dut (
        .clk                     (clk),
        .reset                   (reset),
        .prog                    (prog),
        .encrypters_result       (encrypters_result),
        .encrypters_result_valid (encrypters_result_valid),
        .encrypters_result_ack   (encrypters_result_ack),
        .qspi_out_data           (qspi_out_data),
        .qspi_out_valid          (qspi_out_valid),
        .qspi_out_ready          (qspi_out_ready),
        .state_out               (state_out),
        .encrypter_index_out     (encrypter_index_out),
        .nibble_index_out        (nibble_index_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // one clock: log the handshake before the edge, then emulate encrypters dropping valid on ack
    task automatic step();
        @(negedge clk);
        s_data  = qspi_out_data;
        s_valid = qspi_out_valid;
        s_ready = qspi_out_ready;
        if (!s_valid) idle_cnt++;
        if (s_valid && s_ready) got_nib.push_back(s_data);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (encrypters_result_ack[i]) begin
                got_ack.push_back(i);
                encrypters_result_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic clear_logs();
        got_nib.delete();
        got_ack.delete();
        exp_nib.delete();
        exp_ack.delete();
        idle_cnt = 0;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 8; i++) exp_nib.push_back(w[31-4*i -: 4]);
    endtask

    task automatic compare_logs(input string tag);
        check({tag, "_nib_count"}, got_nib.size(), exp_nib.size());
        for (int i = 0; i < got_nib.size() && i < exp_nib.size(); i++)
            check($sformatf("%s_nib%0d", tag, i), got_nib[i], exp_nib[i]);
        check({tag, "_ack_count"}, got_ack.size(), exp_ack.size());
        for (int i = 0; i < got_ack.size() && i < exp_ack.size(); i++)
            check($sformatf("%s_ack%0d", tag, i), got_ack[i], exp_ack[i]);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        clear_logs();
    endtask

    initial begin
        logic [3:0] held;
        logic       have_hold;

        reset = 1'b1;
        prog = 1'b0;
        qspi_out_ready = 1'b0;
        encrypters_result_valid = '0;
        for (int i = 0; i < N; i++) encrypters_result[i] = '0;
        step();
        step();
        check("rst_valid", qspi_out_valid, 0);
        check("rst_data", qspi_out_data, 0);
        check("rst_ack", encrypters_result_ack, 0);
        check("rst_state", state_out, 0);
        check("rst_idx", encrypter_index_out, 0);
        check("rst_nib", nibble_index_out, 0);
        reset = 1'b0;
        clear_logs();

        // basic block on lane 0
        encrypters_result[0] = 32'h12345678;
        encrypters_result_valid[0] = 1'b1;
        qspi_out_ready = 1'b1;
        step();
        check("basic_ack", encrypters_result_ack, 4'b0001);
        check("basic_valid", qspi_out_valid, 1);
        check("basic_first", qspi_out_data, 4'h1);
        check("basic_nibidx", nibble_index_out, 0);
        check("basic_state_send", state_out, 1);
        step();
        check("basic_ack_once", encrypters_result_ack, 0);
        repeat (7) step();
        for (int i = 1; i <= 8; i++) exp_nib.push_back(4'(i));
        exp_ack.push_back(0);
        compare_logs("basic");
        check("basic_idx", encrypter_index_out, 1);
        check("basic_state_wait", state_out, 0);
        check("basic_valid_end", qspi_out_valid, 0);

        // all lanes valid: strict order, wrap, no bubbles
        reset_dut();
        for (int i = 0; i < N; i++) begin
            encrypters_result[i] = 32'hA0000000 + i;
            encrypters_result_valid[i] = 1'b1;
        end
        qspi_out_ready = 1'b1;
        step();
        idle_cnt = 0;
        repeat (32) step();
        for (int i = 0; i < N; i++) begin
            push_word(32'hA0000000 + i);
            exp_ack.push_back(i);
        end
        compare_logs("wrap");
        check("wrap_idle", idle_cnt, 0);
        check("wrap_idx", encrypter_index_out, 0);
        check("wrap_state", state_out, 0);

        // backpressure with ready pattern 1,0,0
        reset_dut();
        encrypters_result[0] = 32'h12345678;
        encrypters_result_valid[0] = 1'b1;
        qspi_out_ready = 1'b1;
        step();
        have_hold = 1'b0;
        held = '0;
        for (int c = 0; c < 60 && got_nib.size() < 8; c++) begin
            qspi_out_ready = (c % 3 == 0);
            step();
            if (have_hold) check("bp_hold", s_data, held);
            have_hold = s_valid && !s_ready;
            held = s_data;
        end
        for (int i = 1; i <= 8; i++) exp_nib.push_back(4'(i));
        exp_ack.push_back(0);
        compare_logs("bp");

        // lane 2 valid out of turn
        reset_dut();
        encrypters_result[2] = 32'hC0FFEE02;
        encrypters_result_valid[2] = 1'b1;
        qspi_out_ready = 1'b1;
        repeat (10) step();
        check("ooo_no_ack", got_ack.size(), 0);
        check("ooo_no_nib", got_nib.size(), 0);
        check("ooo_valid", qspi_out_valid, 0);
        encrypters_result[0] = 32'h10FEDCBA;
        encrypters_result[1] = 32'h2468ACE1;
        encrypters_result_valid[1:0] = 2'b11;
        repeat (25) step();
        push_word(32'h10FEDCBA);
        push_word(32'h2468ACE1);
        push_word(32'hC0FFEE02);
        exp_ack.push_back(0);
        exp_ack.push_back(1);
        exp_ack.push_back(2);
        compare_logs("ooo");
        check("ooo_idx", encrypter_index_out, 3);

        // prog after three nibbles of lane 1
        reset_dut();
        encrypters_result[0] = 32'h13572468;
        encrypters_result[1] = 32'h9ABCDEF0;
        encrypters_result_valid[1:0] = 2'b11;
        qspi_out_ready = 1'b1;
        repeat (12) step();
        qspi_out_ready = 1'b0;
        prog = 1'b1;
        step();
        prog = 1'b0;
        qspi_out_ready = 1'b1;
        check("prog_valid", qspi_out_valid, 0);
        check("prog_idx", encrypter_index_out, 0);
        check("prog_nib", nibble_index_out, 0);
        check("prog_state", state_out, 0);
        check("prog_data", qspi_out_data, 0);
        check("prog_ack", encrypters_result_ack, 0);
        push_word(32'h13572468);
        exp_nib.push_back(4'h9);
        exp_nib.push_back(4'hA);
        exp_nib.push_back(4'hB);
        exp_ack.push_back(0);
        exp_ack.push_back(1);
        compare_logs("prog");
        clear_logs();
        repeat (10) step();
        compare_logs("prog_after");

        // reset mid-block with all lanes valid, then reset together with prog
        for (int i = 0; i < N; i++) begin
            encrypters_result[i] = 32'hF0000000 + i;
            encrypters_result_valid[i] = 1'b1;
        end
        qspi_out_ready = 1'b0;
        step();
        check("rst2_pre_data", qspi_out_data, 4'hF);
        encrypters_result_valid[0] = 1'b1;
        reset = 1'b1;
        step();
        check("rst2_valid", qspi_out_valid, 0);
        check("rst2_data", qspi_out_data, 0);
        check("rst2_ack", encrypters_result_ack, 0);
        check("rst2_idx", encrypter_index_out, 0);
        prog = 1'b1;
        step();
        check("rstprog_valid", qspi_out_valid, 0);
        check("rstprog_ack", encrypters_result_ack, 0);
        check("rstprog_state", state_out, 0);
        check("rstprog_nib", nibble_index_out, 0);
        reset = 1'b0;
        prog = 1'b0;
        step();
        check("release_ack", encrypters_result_ack, 4'b0001);
        check("release_valid", qspi_out_valid, 1);
        check("release_data", qspi_out_data, 4'hF);
        check("release_idx", encrypter_index_out, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
